// File: rtl/fetch_pkg.sv
// Shared fetch-side types and line geometry, used by the line-fill engine and the fetch cache.
package fetch_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned LINE_W         = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/fetch_line_assembler.sv
// Four word registers forming one cache line.
// Each word is written individually by index and cleared synchronously.
module fetch_line_assembler #(
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  we,
  input  logic [1:0]            idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [4*WORD_W-1:0]   line_out
);
  import fetch_pkg::*;

  logic [WORD_W-1:0] word_q [WORDS_PER_LINE];
  logic [WORD_W-1:0] word_d [WORDS_PER_LINE];

  always_comb begin
    word_d = word_q;
    if (we) word_d[idx] = wdata;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < WORDS_PER_LINE; i++) word_q[i] <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  always_comb begin
    line_out = '0;
    for (int unsigned i = 0; i < WORDS_PER_LINE; i++)
      line_out[i*WORD_W +: WORD_W] = word_q[i];
  end

endmodule

// File: rtl/fetch_line_fill.sv
// Instruction-cache line fill engine: fetches the four words of a missing line.
// Define FETCH_LINE_FILL_CWF_EN to start at the missing word and wrap (critical word first).
module fetch_line_fill #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_W-1:0]     miss_addr,
  input  logic                  flush,
  output logic                  busy,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [WORD_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic [4*WORD_W-1:0]   line_out,
  output logic                  line_valid
);
  import fetch_pkg::*;

  fill_state_e       state_q, state_d;
  logic [ADDR_W-3:0] line_q, line_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        start_idx;
  logic              wr_en;

`ifdef FETCH_LINE_FILL_CWF_EN
  assign start_idx = miss_addr[1:0];
`else
  logic unused_offset;
  assign unused_offset = ^miss_addr[1:0];
  assign start_idx     = 2'b00;
`endif

  // idx_q walks the line mod 4; cnt_q counts accepted words independently of the start word.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_req && !flush) begin
          state_d = FILL;
          line_d  = miss_addr[ADDR_W-1:2];
          idx_d   = start_idx;
          cnt_d   = 2'd0;
        end
      end
      FILL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          wr_en = 1'b1;
          idx_d = idx_q + 2'd1;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_rd     = (state_q == FILL);
  assign mem_addr   = mem_rd ? {line_q, idx_q} : '0;
  assign line_valid = (state_q == DONE) && !flush;

  fetch_line_assembler #(
    .WORD_W (WORD_W)
  ) u_asm (
    .clk      (clk),
    .clear    (rst),
    .we       (wr_en),
    .idx      (idx_q),
    .wdata    (mem_rdata),
    .line_out (line_out)
  );

endmodule

// File: tb/tb_fetch_line_fill.sv
// Directed bench for fetch_line_fill: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_fetch_line_fill;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req;
  logic [31:0]   miss_addr;
  logic          flush;
  logic          busy;
  logic          mem_rd;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic [127:0]  line_out;
  logic          line_valid;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  fetch_line_fill #(
    .ADDR_W (32),
    .WORD_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .flush      (flush),
    .busy       (busy),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .line_out   (line_out),
    .line_valid (line_valid)
  );

  typedef struct {
    logic         rst;
    logic         miss;
    logic [31:0]  addr;
    logic         flush;
    logic         rdy;
    logic [31:0]  data;
    logic         e_busy;
    logic         e_rd;
    logic [31:0]  e_addr;
    logic         e_lv;
    logic         chk_line;
    logic [127:0] e_line;
  } vec_t;

  vec_t vec[$];

  function automatic void r(input logic rs, input logic m, input logic [31:0] a,
                            input logic f, input logic rd_y, input logic [31:0] d,
                            input logic eb, input logic er, input logic [31:0] ea,
                            input logic el);
    vec_t v;
    v.rst = rs; v.miss = m; v.addr = a; v.flush = f; v.rdy = rd_y; v.data = d;
    v.e_busy = eb; v.e_rd = er; v.e_addr = ea; v.e_lv = el;
    v.chk_line = 1'b0; v.e_line = '0;
    vec.push_back(v);
  endfunction

  function automatic void lchk(input logic [127:0] l);
    vec[vec.size()-1].chk_line = 1'b1;
    vec[vec.size()-1].e_line   = l;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input logic rs, input logic m, input logic [31:0] a,
                       input logic f, input logic rd_y, input logic [31:0] d);
    @(negedge clk);
    rst = rs; miss_req = m; miss_addr = a; flush = f; mem_ready = rd_y; mem_rdata = d;
    #1;
  endtask

  initial begin
    logic [1:0] cw;
    int lat;
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; flush = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    @(posedge clk);

    // reset state
    r(1,0,0,0,0,0, 0,0,0,0); lchk('0);
    // plain fill of line 0x40, mem_ready tied high
    r(0,1,32'h40,0,0,0,             0,0,0,0);
    r(0,0,0,0,1,32'h1111_0000,      1,1,32'h40,0);
    r(0,0,0,0,1,32'h1111_0001,      1,1,32'h41,0);
    r(0,0,0,0,1,32'h1111_0002,      1,1,32'h42,0);
    r(0,0,0,0,1,32'h1111_0003,      1,1,32'h43,0);
    r(0,0,0,0,0,0,                  1,0,0,1);
    r(0,0,0,0,0,0,                  0,0,0,0);
    lchk({32'h1111_0003,32'h1111_0002,32'h1111_0001,32'h1111_0000});
    // stall 3 cycles on word 1, with an ignored miss while busy
    r(0,1,32'h44,0,0,0,             0,0,0,0);
    r(0,0,0,0,1,32'h2222_0000,      1,1,32'h44,0);
    r(0,1,32'h99,0,0,32'hdead_beef, 1,1,32'h45,0);
    r(0,1,32'h99,0,0,32'hdead_beef, 1,1,32'h45,0);
    r(0,0,0,0,0,32'hdead_beef,      1,1,32'h45,0);
    r(0,0,0,0,1,32'h2222_0001,      1,1,32'h45,0);
    r(0,0,0,0,1,32'h2222_0002,      1,1,32'h46,0);
    r(0,0,0,0,1,32'h2222_0003,      1,1,32'h47,0);
    r(0,0,0,0,0,0,                  1,0,0,1);
    r(0,0,0,0,0,0,                  0,0,0,0);
    lchk({32'h2222_0003,32'h2222_0002,32'h2222_0001,32'h2222_0000});
    // flush with mem_ready on word 2, then miss 0x80
    r(0,1,32'h40,0,0,0,             0,0,0,0);
    r(0,0,0,0,1,32'h3333_0000,      1,1,32'h40,0);
    r(0,0,0,0,1,32'h3333_0001,      1,1,32'h41,0);
    r(0,0,0,1,1,32'h3333_0002,      1,1,32'h42,0);
    r(0,1,32'h80,0,0,0,             0,0,0,0);
    lchk({32'h2222_0003,32'h2222_0002,32'h3333_0001,32'h3333_0000});
    r(0,0,0,0,1,32'h4444_0000,      1,1,32'h80,0);
    r(0,0,0,0,1,32'h4444_0001,      1,1,32'h81,0);
    r(0,0,0,0,1,32'h4444_0002,      1,1,32'h82,0);
    r(0,0,0,0,1,32'h4444_0003,      1,1,32'h83,0);
    r(0,0,0,0,0,0,                  1,0,0,1);
    r(0,0,0,0,0,0,                  0,0,0,0);
    lchk({32'h4444_0003,32'h4444_0002,32'h4444_0001,32'h4444_0000});
    // flush in DONE suppresses line_valid
    r(0,1,32'h10,0,0,0,             0,0,0,0);
    r(0,0,0,0,1,32'h5555_0000,      1,1,32'h10,0);
    r(0,0,0,0,1,32'h5555_0001,      1,1,32'h11,0);
    r(0,0,0,0,1,32'h5555_0002,      1,1,32'h12,0);
    r(0,0,0,0,1,32'h5555_0003,      1,1,32'h13,0);
    r(0,0,0,1,0,0,                  1,0,0,0);
    r(0,0,0,0,0,0,                  0,0,0,0);
    lchk({32'h5555_0003,32'h5555_0002,32'h5555_0001,32'h5555_0000});
    // flush in IDLE blocks the miss
    r(0,1,32'h30,1,0,0,             0,0,0,0);
    r(0,0,0,0,0,0,                  0,0,0,0);
    // reset during FILL overrides miss and flush
    r(0,1,32'h20,0,0,0,             0,0,0,0);
    r(0,0,0,0,1,32'h6666_0000,      1,1,32'h20,0);
    r(1,1,32'h20,1,1,32'h6666_0001, 1,1,32'h21,0);
    r(0,0,0,0,0,0,                  0,0,0,0); lchk('0);
    r(0,0,0,0,0,0,                  0,0,0,0);

    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].rst, vec[i].miss, vec[i].addr, vec[i].flush, vec[i].rdy, vec[i].data);
      chk($sformatf("row%0d busy", i),       {127'd0, busy},       {127'd0, vec[i].e_busy});
      chk($sformatf("row%0d mem_rd", i),     {127'd0, mem_rd},     {127'd0, vec[i].e_rd});
      chk($sformatf("row%0d mem_addr", i),   {96'd0, mem_addr},    {96'd0, vec[i].e_addr});
      chk($sformatf("row%0d line_valid", i), {127'd0, line_valid}, {127'd0, vec[i].e_lv});
      if (vec[i].chk_line) chk($sformatf("row%0d line_out", i), line_out, vec[i].e_line);
    end

    // unaligned miss, mem_ready every other cycle, bounded wait for line_valid
`ifdef FETCH_LINE_FILL_CWF_EN
    cw = 2'd1;
`else
    cw = 2'd0;
`endif
    drive(0,1,32'h81,0,0,0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      drive(0,0,0,0,(c % 2 == 0), c);
      if (c == 1) chk("alt first mem_addr", {96'd0, mem_addr}, {96'd0, 30'h20, cw});
      if (line_valid) begin lat = c; break; end
    end
    chk("alt latency", lat, 9);
`ifdef FETCH_LINE_FILL_CWF_EN
    chk("alt line_out", line_out, {32'd6, 32'd4, 32'd2, 32'd8});
`else
    chk("alt line_out", line_out, {32'd8, 32'd6, 32'd4, 32'd2});
`endif
    drive(0,0,0,0,0,0);
    chk("alt idle busy", {127'd0, busy}, 128'd0);

`ifdef FETCH_LINE_FILL_CWF_EN
    // critical word first: 0x42 fetches 0x42,0x43,0x40,0x41
    drive(0,1,32'h42,0,0,0);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] w;
      w = 2'(k + 2);
      drive(0,0,0,0,1,32'h7777_0000 + k);
      chk($sformatf("cwf addr%0d", k), {96'd0, mem_addr}, {96'd0, 30'h10, w});
    end
    drive(0,0,0,0,0,0);
    chk("cwf line_valid", {127'd0, line_valid}, 128'd1);
    chk("cwf line_out", line_out, {32'h7777_0001, 32'h7777_0000, 32'h7777_0003, 32'h7777_0002});
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_line_fill.md
FETCH_LINE_FILL -- requirements
Module: fetch_line_fill

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32: byte-free word-address width of miss_addr and mem_addr.
REQ-002 The block SHALL take parameter WORD_W, default 32: width of one instruction word.
REQ-003 The block SHALL have port clk  in  1  clock; all state changes on posedge clk.
REQ-004 The block SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port miss_req  in  1  fetch cache miss request, level.
REQ-006 The block SHALL have port miss_addr  in  ADDR_W  missing word address; [1:0] = word offset in line.
REQ-007 The block SHALL have port flush  in  1  abandon current fill (branch redirect).
REQ-008 The block SHALL have port busy  out  1  fill in progress; miss_req ignored while high.
REQ-009 The block SHALL have port mem_rd  out  1  instruction memory read request.
REQ-010 The block SHALL have port mem_addr  out  ADDR_W  instruction memory word address.
REQ-011 The block SHALL have port mem_rdata  in  WORD_W  instruction memory read data.
REQ-012 The block SHALL have port mem_ready  in  1  mem_rdata valid for current mem_addr this cycle.
REQ-013 The block SHALL have port line_out  out  4*WORD_W  assembled line; word k at bits [k*WORD_W +: WORD_W].
REQ-014 The block SHALL have port line_valid  out  1  one-cycle pulse: line_out complete, cache may install it.

Function
REQ-015 The block SHALL implement FSM states IDLE, FILL, DONE.
REQ-016 In IDLE, miss_req=1 and flush=0 SHALL latch base = {miss_addr[ADDR_W-1:2],2'b00}, set word index, and enter FILL next cycle.
REQ-017 In FILL, mem_rd SHALL be 1 and mem_addr SHALL equal base + index; busy=1.
REQ-018 On mem_ready=1 in FILL, mem_rdata SHALL be written to line word[index]; index increments mod 4; other words hold.
REQ-019 After the 4th accepted word, the FSM SHALL enter DONE; mem_rd drops in that same transition.
REQ-020 In DONE, line_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; line_out holds until the next fill starts.
REQ-021 Minimum miss-to-line_valid latency SHALL be 5 cycles (1 accept + 4 words with mem_ready tied high).
REQ-022 mem_ready=0 SHALL stall FILL indefinitely with mem_addr stable; no timeout.
REQ-023 flush=1 in FILL or DONE SHALL return to IDLE next cycle, line_valid=0, mem_rd=0; flush beats same-cycle mem_ready (word discarded).
REQ-024 miss_req during FILL/DONE SHALL be ignored; the requester re-asserts after busy falls.
REQ-025 busy SHALL be 1 in FILL and DONE, 0 in IDLE.
REQ-026 mem_addr SHALL wrap within the line (base..base+3) and never cross into the next line.

Reset
REQ-027 rst=1 SHALL force IDLE, busy=0, mem_rd=0, mem_addr=0, line_valid=0, line_out=0, index=0.
REQ-028 rst during FILL SHALL abandon the fill with no line_valid; rst overrides flush and miss_req.

Configuration
REQ-029 With FETCH_LINE_FILL_CWF_EN defined, the fill SHALL start at index = miss_addr[1:0] and wrap (critical word first).
REQ-030 Without FETCH_LINE_FILL_CWF_EN, the fill SHALL always start at index 0 and proceed 0,1,2,3.

Structure
REQ-031 Package fetch_pkg SHALL hold WORD_W, LINE_W=128, WORDS_PER_LINE=4, and the fill state enum; shared with the fetch cache.
REQ-032 Word-enable line storage SHALL be sub-module fetch_line_assembler (4 word registers, write enable, index select, clear).

Verification
REQ-033 miss_addr=0x40 (word), mem_ready=1 -> mem_addr 0x40,41,42,43; line_valid at cycle 5; line_out = {d3,d2,d1,d0}.
REQ-034 CWF_EN, miss_addr=0x42 -> mem_addr 0x42,43,40,41; line_out word2=first data returned.
REQ-035 mem_ready low for 3 cycles on word 1 -> mem_addr holds base+1, line_valid delayed by exactly 3 cycles.
REQ-036 flush with mem_ready on word 2 -> IDLE next cycle, no line_valid; new miss 0x80 completes correctly.
REQ-037 Second miss_req while busy -> ignored; rst in FILL -> all outputs 0 next cycle, no line_valid.
